// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB3 initiator.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } apb_state_t;

  localparam int APB_DATA_W = 32;
  localparam int TO_CNT_W   = 16;

endpackage

// File: rtl/apb_master_seq.sv
// APB3 initiator: each accepted request becomes one APB transfer; the result comes back on the response port.
// Optional ACCESS-phase watchdog is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_seq
  import apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [APB_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_DATA_W-1:0] PWDATA,
  input  logic [APB_DATA_W-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_master_seq: TIMEOUT_CYCLES must be in 2..65535");
  end

  apb_state_t state, state_nxt;
  logic       capture_req;
  logic       capture_rsp;
  logic       timeout;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt;

  // SETUP always precedes ACCESS, so clearing there means the count starts at 0 on entry.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      to_cnt <= '0;
    end else if (state == SETUP) begin
      to_cnt <= '0;
    end else if (state == ACCESS && !PREADY) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = (state == ACCESS) && !PREADY &&
                   (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake signals are pure state decodes, so reset drops PSEL/PENABLE without waiting for an edge.
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    PSEL        = 1'b0;
    PENABLE     = 1'b0;
    rsp_valid   = 1'b0;
    capture_req = 1'b0;
    capture_rsp = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture_req = 1'b1;
          state_nxt   = SETUP;
        end
      end
      SETUP: begin
        PSEL      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY || timeout) begin
          capture_rsp = 1'b1;
          state_nxt   = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address, direction and write data persist after the transfer; only a new request changes them.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
    end else if (capture_req) begin
      PADDR  <= req_addr;
      PWRITE <= req_write;
      PWDATA <= req_wdata;
    end
  end

  // Normal completion takes priority over a watchdog abort in the same cycle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (capture_rsp) begin
      if (PREADY) begin
        rsp_err   <= PSLVERR;
        rsp_rdata <= (PSLVERR || PWRITE) ? '0 : PRDATA;
      end else begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_seq.sv
// Directed bench for apb_master_seq: write, waited read, slave error, response backpressure,
// long wait or watchdog abort (APB_MASTER_TIMEOUT_EN), and reset during ACCESS.
module tb_apb_master_seq;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 PCLK = ~PCLK;

  apb_master_seq #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge PCLK);
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  initial begin
    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    nclk(); nclk();

    // Reset state
    chk("rst_req_ready", req_ready, 1);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_err", rsp_err, 0);
    PRESET = 1'b0;

    // Zero-wait write
    issue(1'b1, 32'h08, 32'hDEADBEEF);
    PREADY = 1'b1; rsp_ready = 1'b1;
    chk("wr_req_ready_idle", req_ready, 1);
    nclk();
    chk("wr_c1_psel", PSEL, 1);
    chk("wr_c1_penable", PENABLE, 0);
    chk("wr_c1_req_ready", req_ready, 0);
    chk("wr_c1_paddr", PADDR, 32'h08);
    chk("wr_c1_pwrite", PWRITE, 1);
    chk("wr_c1_pwdata", PWDATA, 32'hDEADBEEF);
    req_valid = 1'b0;
    nclk();
    chk("wr_c2_psel", PSEL, 1);
    chk("wr_c2_penable", PENABLE, 1);
    chk("wr_c2_rsp_valid", rsp_valid, 0);
    nclk();
    chk("wr_c3_rsp_valid", rsp_valid, 1);
    chk("wr_c3_rsp_err", rsp_err, 0);
    chk("wr_c3_rsp_rdata", rsp_rdata, 0);
    chk("wr_c3_psel", PSEL, 0);
    chk("wr_c3_penable", PENABLE, 0);
    nclk();
    chk("wr_c4_rsp_valid", rsp_valid, 0);
    chk("wr_c4_req_ready", req_ready, 1);
    chk("wr_c4_paddr_hold", PADDR, 32'h08);

    // Read with 3 wait states; PRDATA is junk until PREADY rises
    issue(1'b0, 32'h04, 32'h0);
    PRDATA = 32'hBAD0BAD0;
    nclk();
    chk("rd_c1_psel", PSEL, 1);
    req_valid = 1'b0;
    nclk();
    chk("rd_c2_penable", PENABLE, 1);
    PREADY = 1'b0;
    nclk();
    chk("rd_c3_penable", PENABLE, 1);
    chk("rd_c3_paddr", PADDR, 32'h04);
    chk("rd_c3_rsp_valid", rsp_valid, 0);
    nclk();
    chk("rd_c4_psel", PSEL, 1);
    chk("rd_c4_paddr", PADDR, 32'h04);
    nclk();
    chk("rd_c5_penable", PENABLE, 1);
    chk("rd_c5_paddr", PADDR, 32'h04);
    PREADY = 1'b1; PRDATA = 32'h12345678;
    nclk();
    chk("rd_c6_rsp_valid", rsp_valid, 1);
    chk("rd_c6_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("rd_c6_rsp_err", rsp_err, 0);
    nclk();
    chk("rd_c7_rsp_valid", rsp_valid, 0);

    // Slave error on a read
    issue(1'b0, 32'h10, 32'h0);
    PSLVERR = 1'b1; PRDATA = 32'hCAFEF00D;
    nclk();
    chk("err_c1_psel", PSEL, 1);
    req_valid = 1'b0;
    nclk();
    chk("err_c2_penable", PENABLE, 1);
    nclk();
    chk("err_c3_rsp_valid", rsp_valid, 1);
    chk("err_c3_rsp_err", rsp_err, 1);
    chk("err_c3_rsp_rdata", rsp_rdata, 0);
    nclk();
    PSLVERR = 1'b0;
    chk("err_c4_rsp_valid", rsp_valid, 0);

    // Response backpressure with a second request held waiting
    issue(1'b1, 32'h0C, 32'h11112222);
    rsp_ready = 1'b0;
    nclk();
    chk("bp_c1_psel", PSEL, 1);
    req_valid = 1'b0;
    nclk();
    nclk();
    issue(1'b0, 32'h14, 32'h0);
    PRDATA = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_req_ready", req_ready, 0);
      chk("bp_hold_psel", PSEL, 0);
      chk("bp_hold_rsp_valid", rsp_valid, 1);
      if (i == 4) rsp_ready = 1'b1;
      else nclk();
    end
    nclk();
    chk("bp_idle_req_ready", req_ready, 1);
    chk("bp_idle_rsp_valid", rsp_valid, 0);
    chk("bp_idle_psel", PSEL, 0);
    nclk();
    chk("bp_setup2_psel", PSEL, 1);
    chk("bp_setup2_penable", PENABLE, 0);
    chk("bp_setup2_paddr", PADDR, 32'h14);
    chk("bp_setup2_pwrite", PWRITE, 0);
    req_valid = 1'b0;
    nclk();
    chk("bp_access2_penable", PENABLE, 1);
    nclk();
    chk("bp_resp2_rsp_valid", rsp_valid, 1);
    chk("bp_resp2_rsp_rdata", rsp_rdata, 32'h0BADF00D);
    nclk();

    // Stalled slave: watchdog abort, or an indefinite wait without the watchdog
    issue(1'b0, 32'h20, 32'h0);
    PREADY = 1'b0; PRDATA = 32'h55AA55AA;
    nclk();
    req_valid = 1'b0;
    nclk();
`ifdef APB_MASTER_TIMEOUT_EN
    repeat (3) nclk();
    chk("to_c5_psel", PSEL, 1);
    chk("to_c5_penable", PENABLE, 1);
    nclk();
    chk("to_c6_psel", PSEL, 0);
    chk("to_c6_rsp_valid", rsp_valid, 1);
    chk("to_c6_rsp_err", rsp_err, 1);
    chk("to_c6_rsp_rdata", rsp_rdata, 0);
`else
    for (int i = 0; i < 10; i++) begin
      chk("wait_psel", PSEL, 1);
      chk("wait_penable", PENABLE, 1);
      if (i == 9) PREADY = 1'b1;
      else nclk();
    end
    nclk();
    chk("wait_rsp_valid", rsp_valid, 1);
    chk("wait_rsp_rdata", rsp_rdata, 32'h55AA55AA);
    chk("wait_rsp_err", rsp_err, 0);
`endif
    nclk();
    chk("stall_idle_rsp_valid", rsp_valid, 0);

    // Reset asserted during an ACCESS wait state
    issue(1'b0, 32'h24, 32'h0);
    PREADY = 1'b0;
    nclk();
    req_valid = 1'b0;
    nclk();
    nclk();
    chk("rst_mid_psel_before", PSEL, 1);
    #2 PRESET = 1'b1;
    #1;
    chk("rst_mid_psel", PSEL, 0);
    chk("rst_mid_penable", PENABLE, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    nclk();
    PRESET = 1'b0; PREADY = 1'b1;
    nclk();
    chk("rst_rel_req_ready", req_ready, 1);
    chk("rst_rel_rsp_valid", rsp_valid, 0);
    chk("rst_rel_psel", PSEL, 0);
    chk("rst_rel_paddr", PADDR, 0);
    nclk();
    chk("rst_rel2_rsp_valid", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
